// File: rtl/audio_dac_out_pkg.sv
// rtl/audio_dac_out_pkg.sv - shared sample type and clock-divider bit positions for audio_dac_out
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int MCLK_BIT   = 1;
    localparam int SCLK_BIT   = 3;
    localparam int LRCK_BIT   = 9;
    localparam int DATA_SLOTS = 16;

endpackage

// File: rtl/audio_dac_out_if.sv
// rtl/audio_dac_out_if.sv - sample inputs and DAC/jack pins of the audio output stage
import audio_pkg::*;

interface audio_dac_out_if;

    sample_t l_data;
    sample_t r_data;
    logic    dac_mclk;
    logic    dac_sclk;
    logic    dac_lrck;
    logic    dac_sdin;
    logic    sigma_l;
    logic    sigma_r;

    // master is the mixer side supplying samples; slave is the output stage
    modport master (
        output l_data, r_data,
        input  dac_mclk, dac_sclk, dac_lrck, dac_sdin, sigma_l, sigma_r
    );

    modport slave (
        input  l_data, r_data,
        output dac_mclk, dac_sclk, dac_lrck, dac_sdin, sigma_l, sigma_r
    );

endinterface

// File: rtl/audio_dac_out_sigma_delta_1st.sv
// rtl/audio_dac_out_sigma_delta_1st.sv - first-order sigma-delta modulator for one audio channel
import audio_pkg::*;

module sigma_delta_1st (
    input  logic    clock,
    input  logic    reset,
    input  sample_t sample,
    output logic    sigma
);

    logic [15:0] u;
    logic [16:0] acc;

    // flipping the sign bit maps two's complement onto offset binary
    assign u = {~sample[15], sample[14:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= 17'd0;
        end else begin
            acc <= {1'b0, acc[15:0]} + {1'b0, u};
        end
    end

    assign sigma = acc[16];

endmodule

// File: rtl/audio_dac_out.sv
// rtl/audio_dac_out.sv - I2S DAC driver plus optional sigma-delta jack outputs (AUDIO_SIGMA_EN)
import audio_pkg::*;

module audio_dac_out #(
    parameter int FRAME_LOG2 = 10
) (
    input  logic            clock,
    input  logic            reset,
    audio_dac_out_if.slave  bus
);

    generate
        if (FRAME_LOG2 != 10) begin : g_bad_frame
            $error("audio_dac_out: only FRAME_LOG2 = 10 is supported");
        end
    endgenerate

    logic [FRAME_LOG2-1:0] cnt;
    sample_t               sl;
    sample_t               sr;
    logic                  sdin_q;

    logic [5:0]            nxt_hi;
    logic [4:0]            nxt_slot;
    logic                  nxt_ch;
    sample_t               nxt_word;
    logic [3:0]            bit_pos;
    logic                  nxt_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            sl  <= '0;
            sr  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            // both channels latch together at the frame wrap so a frame is never torn
            if (cnt == '1) begin
                sl <= bus.l_data;
                sr <= bus.r_data;
            end
        end
    end

    // data for the slot being entered on the next SCLK falling edge
    always_comb begin
        nxt_hi   = 6'd0;
        nxt_slot = 5'd0;
        nxt_ch   = 1'b0;
        nxt_word = '0;
        bit_pos  = 4'd0;
        nxt_bit  = 1'b0;

        nxt_hi   = cnt[LRCK_BIT:SCLK_BIT+1] + 6'd1;
        nxt_slot = nxt_hi[4:0];
        nxt_ch   = nxt_hi[5];
        nxt_word = nxt_ch ? sr : sl;
        bit_pos  = 4'(5'(DATA_SLOTS) - nxt_slot);
        if (nxt_slot != 5'd0 && nxt_slot <= 5'(DATA_SLOTS)) begin
            nxt_bit = nxt_word[bit_pos];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sdin_q <= 1'b0;
        end else if (cnt[SCLK_BIT:0] == '1) begin
            sdin_q <= nxt_bit;
        end
    end

    assign bus.dac_mclk = cnt[MCLK_BIT];
    assign bus.dac_sclk = cnt[SCLK_BIT];
    assign bus.dac_lrck = cnt[LRCK_BIT];
    assign bus.dac_sdin = sdin_q;

`ifdef AUDIO_SIGMA_EN
    sigma_delta_1st u_sigma_l (
        .clock  (clock),
        .reset  (reset),
        .sample (sl),
        .sigma  (bus.sigma_l)
    );

    sigma_delta_1st u_sigma_r (
        .clock  (clock),
        .reset  (reset),
        .sample (sr),
        .sigma  (bus.sigma_r)
    );
`else
    assign bus.sigma_l = 1'b0;
    assign bus.sigma_r = 1'b0;
`endif

endmodule

// File: tb/tb_audio_dac_out.sv
// tb/tb_audio_dac_out.sv - randomized self-checking bench for audio_dac_out against a frame-level model
import audio_pkg::*;

module tb_audio_dac_out;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    audio_dac_out_if bus ();

    audio_dac_out #(.FRAME_LOG2(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    int          n;
    logic [15:0] m_sl, m_sr;
    longint      s_l, s_r;
    logic        exp_l, exp_r;
    logic [15:0] rx_l, rx_r, last_l, last_r;
    int          ones_l, ones_r, same_l;
    logic        prev_l;

    task automatic check_eq(input string tag, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    function automatic longint offset_u(input logic [15:0] s);
        return longint'($signed(s)) + 64'sd32768;
    endfunction

    // one clock: advance the model, then check the DUT 1 ns after the edge
    task automatic step();
        int     c, cn, slot;
        longint old;
        @(posedge clock);
        if (reset) begin
            n = 0; m_sl = '0; m_sr = '0; s_l = 0; s_r = 0; exp_l = 1'b0; exp_r = 1'b0;
        end else begin
            c = n % 1024;
            old = s_l; s_l = s_l + offset_u(m_sl); exp_l = ((s_l >>> 16) - (old >>> 16)) != 0;
            old = s_r; s_r = s_r + offset_u(m_sr); exp_r = ((s_r >>> 16) - (old >>> 16)) != 0;
            if (c == 1023) begin
                m_sl = bus.l_data;
                m_sr = bus.r_data;
            end
            n++;
        end
        #1;
        cn = n % 1024;
        check_eq("mclk", bus.dac_mclk, (cn / 2) % 2);
        check_eq("sclk", bus.dac_sclk, (cn / 8) % 2);
        check_eq("lrck", bus.dac_lrck, cn / 512);
`ifdef AUDIO_SIGMA_EN
        check_eq("sigma_l", bus.sigma_l, exp_l);
        check_eq("sigma_r", bus.sigma_r, exp_r);
`else
        check_eq("sigma_l_off", bus.sigma_l, 0);
        check_eq("sigma_r_off", bus.sigma_r, 0);
`endif
        ones_l += int'(bus.sigma_l);
        ones_r += int'(bus.sigma_r);
        if (reset) begin
            check_eq("sdin_reset", bus.dac_sdin, 0);
        end else begin
            if (cn % 16 == 8) begin
                slot = (cn / 16) % 32;
                if (slot >= 1 && slot <= DATA_SLOTS) begin
                    if (cn < 512) rx_l = {rx_l[14:0], bus.dac_sdin};
                    else          rx_r = {rx_r[14:0], bus.dac_sdin};
                end else begin
                    check_eq("sdin_idle_slot", bus.dac_sdin, 0);
                end
            end
            if (cn == 511) begin
                check_eq("i2s_left_word", rx_l, m_sl);
                last_l = rx_l;
            end
            if (cn == 1023) begin
                check_eq("i2s_right_word", rx_r, m_sr);
                last_r = rx_r;
            end
        end
    endtask

    task automatic run_to_wrap();
        step();
        while (n % 1024 != 0) step();
    endtask

    initial begin
        n = 0; m_sl = '0; m_sr = '0; s_l = 0; s_r = 0; exp_l = 1'b0; exp_r = 1'b0;
        rx_l = '0; rx_r = '0; last_l = '0; last_r = '0;
        ones_l = 0; ones_r = 0; same_l = 0; prev_l = 1'b0;
        bus.l_data = '0;
        bus.r_data = '0;

        reset = 1'b1;
        repeat (5) step();
        reset = 1'b0;

        bus.l_data = 16'hA5C3;
        bus.r_data = 16'h0001;
        run_to_wrap();
        run_to_wrap();
        check_eq("plan_left_a5c3", last_l, 16'hA5C3);
        check_eq("plan_right_0001", last_r, 16'h0001);

        bus.l_data = 16'h1234;
        run_to_wrap();
        while (n % 1024 != 300) step();
        bus.l_data = 16'hFFFF;
        run_to_wrap();
        check_eq("late_change_keeps_1234", last_l, 16'h1234);
        run_to_wrap();
        check_eq("next_frame_ffff", last_l, 16'hFFFF);

        repeat (4) begin
            int cut;
            bus.l_data = 16'($urandom);
            bus.r_data = 16'($urandom);
            cut = int'($urandom_range(1, 1000));
            while (n % 1024 != cut) step();
            bus.l_data = 16'($urandom);
            bus.r_data = 16'($urandom);
            run_to_wrap();
        end
        run_to_wrap();

        bus.l_data = 16'h8000;
        bus.r_data = 16'h7FFF;
        run_to_wrap();
        ones_l = 0; ones_r = 0;
        repeat (65536) step();
`ifdef AUDIO_SIGMA_EN
        check_eq("sigma_min_ones", ones_l, 0);
        check_eq("sigma_max_ones", ones_r, 65535);
`else
        check_eq("sigma_min_ones_off", ones_l, 0);
        check_eq("sigma_max_ones_off", ones_r, 0);
`endif

        bus.l_data = 16'h0000;
        run_to_wrap();
        ones_l = 0; same_l = 0;
        step();
        prev_l = bus.sigma_l;
        repeat (1023) begin
            step();
            if (bus.sigma_l == prev_l) same_l++;
            prev_l = bus.sigma_l;
        end
`ifdef AUDIO_SIGMA_EN
        check_eq("sigma_half_ones_511_513", (ones_l >= 511 && ones_l <= 513), 1);
        check_eq("sigma_half_alternates", same_l, 0);
`else
        check_eq("sigma_half_ones_off", ones_l, 0);
`endif

        bus.l_data = 16'($urandom) | 16'h0101;
        bus.r_data = 16'($urandom) | 16'h0101;
        run_to_wrap();
        while (n % 1024 != 700) step();
        reset = 1'b1;
        step();
        check_eq("rst_mid_lrck", bus.dac_lrck, 0);
        check_eq("rst_mid_sdin", bus.dac_sdin, 0);
        check_eq("rst_mid_mclk", bus.dac_mclk, 0);
        check_eq("rst_mid_sclk", bus.dac_sclk, 0);
        check_eq("rst_mid_sigma_l", bus.sigma_l, 0);
        check_eq("rst_mid_sigma_r", bus.sigma_r, 0);
        reset = 1'b0;
        run_to_wrap();
        check_eq("rst_frame_left_zero", last_l, 0);
        check_eq("rst_frame_right_zero", last_r, 0);
        run_to_wrap();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/audio_dac_out.md
Name: audio_dac_out

Overview:
- Host-side audio output stage of the board I/O bridge.
- Takes the core's 16-bit signed left/right samples and drives an external I2S DAC (MCLK, SCLK, LRCK, SDIN).
- Also drives two 1-bit first-order sigma-delta pins for the analogue RC-filtered audio jack.
- Sits between the machine core's audio mixer and the board audio pins; runs on the 50 MHz board clock.

Parameters:
- FRAME_LOG2, 10, log2 of clock cycles per stereo frame. Fixed ratios: MCLK = clock/4, SCLK = clock/16, LRCK = clock/1024 (48.828 kHz at 50 MHz). Only 10 is supported; others are rejected by an elaboration assertion.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- l_data  in  16  left sample, two's complement
- r_data  in  16  right sample, two's complement
- dac_mclk  out  1  I2S master clock
- dac_sclk  out  1  I2S bit clock
- dac_lrck  out  1  I2S word select (0 = left, 1 = right)
- dac_sdin  out  1  I2S serial data
- sigma_l  out  1  left sigma-delta bitstream
- sigma_r  out  1  right sigma-delta bitstream

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: cnt (10-bit free-running counter), both sample shadow registers, both sigma accumulators and all outputs go to 0.
- Counter:
  - cnt increments by 1 every clock and wraps 1023 -> 0.
  - dac_mclk = cnt[1], dac_sclk = cnt[3], dac_lrck = cnt[9]. Each is a direct flop bit, so no glitches.
- Sample capture:
  - On the clock edge where cnt goes 1023 -> 0, l_data and r_data are captured together into shadow registers sl and sr.
  - Input changes at any other time do not affect the current frame.
  - First capture after reset happens at the first wrap; until then the shadows hold 0.
- Serialiser:
  - slot = cnt[8:4] (0..31) within each half-frame; channel word = sl when cnt[9] = 0, sr when cnt[9] = 1.
  - dac_sdin is a flop updated on the edge where cnt[3:0] becomes 0000, i.e. on SCLK falling edges.
  - The new value corresponds to the slot being entered.
  - Slot k in 1..16 carries word bit (16-k), so the MSB appears one SCLK after the LRCK edge (Philips I2S). Slots 0 and 17..31 carry 0.
  - The DAC samples on the SCLK rising edge, 8 clocks after the data change.
- Sigma-delta, per channel, every clock:
  - u = {~s[15], s[14:0]} (offset binary from the shadow sample).
  - acc (17 bits) <= {1'b0, acc[15:0]} + u; sigma = acc[16] (registered).
  - Long-run density of ones = u/65536: 0x8000 -> always 0, 0x0000 -> 50 %, 0x7FFF -> 1 except one clock in 65536.
- Reset asserted mid-frame: everything returns to the reset state on the next edge; the frame restarts from cnt = 0 with zero samples.

Optional Feature:
- Macro AUDIO_SIGMA_EN.
- Defined: the sigma-delta accumulators are built and sigma_l/sigma_r behave as above.
- Undefined: no accumulators; sigma_l and sigma_r are tied to 0. The I2S path is unchanged.

Decomposition:
- Shared package audio_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - constants MCLK_BIT = 1, SCLK_BIT = 3, LRCK_BIT = 9, DATA_SLOTS = 16.
- One sub-module is natural: sigma_delta_1st (clock, reset, sample_t in, 1-bit out), instantiated twice under AUDIO_SIGMA_EN.

Test Plan:
- Reset held 5 cycles, then released:
  - all outputs 0 during reset;
  - dac_mclk toggles every 2 clocks, dac_sclk every 8, dac_lrck every 512 after release.
- l_data = 0xA5C3, r_data = 0x0001, captured at the first wrap:
  - next frame left slots 1..16 sample as 1010010111000011 on SCLK rising edges;
  - right slots as 0000000000000001; all other slots 0.
- l_data changed from 0x1234 to 0xFFFF at cnt = 300: the remainder of that frame still serialises 0x1234; the next frame sends 0xFFFF.
- AUDIO_SIGMA_EN defined, l_data = 0x8000, r_data = 0x7FFF for 65536 clocks after capture:
  - sigma_l ones count = 0;
  - sigma_r ones count = 65535.
- AUDIO_SIGMA_EN defined, l_data = 0x0000 for 1024 clocks: sigma_l alternates 0/1 and the ones count = 512 ±1.
- Reset pulsed at cnt = 700 with samples nonzero: next edge shows dac_lrck = 0, dac_sdin = 0, cnt restarting at 0, sigma outputs 0.
